// File: rtl/seq_alu.sv
// seq_alu: sequential ALU, one op in flight; 1-cycle ops latency 1, shifts 1 bit/cycle (latency shamt+1).
// Holds Result/flags while out_ready=0; optional shift-add MUL (WIDTH+1 latency) under `SEQ_ALU_MUL_EN.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             armed;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q, work_n;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q, ovf_q, zero_q, neg_q;

  logic             accept, start, finish, multi, is_shift;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] r1;
  logic             c1, v1;
  logic [WIDTH-1:0] rb;
  logic             cb;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_n;
  logic [WIDTH-1:0]   mplier_q;

  assign prod_n = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif

  assign shamt     = B[SW-1:0];
  assign out_valid = (state == DONE);
  assign Result    = res_q;
  assign Carry     = carry_q;
  assign OverFlow  = ovf_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready = armed && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);
`ifdef SEQ_ALU_MUL_EN
  assign multi = (is_shift && (shamt != '0)) || (ALUControl == OP_MUL);
`else
  assign multi = is_shift && (shamt != '0);
`endif

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  always_comb begin
    add_s = {1'b0, A} + {1'b0, B};
    sub_s = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        r1 = add_s[WIDTH-1:0];
        c1 = add_s[WIDTH];
        v1 = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r1 = sub_s[WIDTH-1:0];
        c1 = sub_s[WIDTH];
        v1 = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  r1 = A & B;
      OP_OR:   r1 = A | B;
      OP_XOR:  r1 = A ^ B;
      OP_SLT:  r1 = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: r1 = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL, OP_SRL, OP_SRA: r1 = A;
      default: r1 = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  work_n = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  work_n = {1'b0, work_q[WIDTH-1:1]};
      default: work_n = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  // Result of the last BUSY cycle
  always_comb begin
    rb = work_n;
    cb = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    if (op_q == OP_MUL) begin
      rb = prod_n[WIDTH-1:0];
      cb = |prod_n[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: start = accept;
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
        start = accept;
      end
      default: state_n = IDLE;
    endcase
    if (start) state_n = multi ? BUSY : DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state <= state_n;
      armed <= 1'b1;
      if (start) begin
        op_q   <= ALUControl;
        work_q <= A;
        cnt_q  <= CW'(shamt);
`ifdef SEQ_ALU_MUL_EN
        prod_q   <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, A};
        mplier_q <= B;
        if (ALUControl == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
        if (!multi) begin
          res_q   <= r1;
          carry_q <= c1;
          ovf_q   <= v1;
          zero_q  <= (r1 == '0);
          neg_q   <= r1[WIDTH-1];
        end
      end else if (state == BUSY) begin
        work_q <= work_n;
        cnt_q  <= cnt_q - CW'(1);
`ifdef SEQ_ALU_MUL_EN
        prod_q   <= prod_n;
        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
`endif
        if (finish) begin
          res_q   <= rb;
          carry_q <= cb;
          ovf_q   <= 1'b0;
          zero_q  <= (rb == '0);
          neg_q   <= rb[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random bench for seq_alu (WIDTH=32) with a result scoreboard.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Carry, OverFlow, Zero, Negative;

  typedef struct {
    logic [31:0] res;
    logic        c, v, z, n;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_res;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Carry(Carry),
    .OverFlow(OverFlow), .Zero(Zero), .Negative(Negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    int          sh;
    sh = int'(b[4:0]);
    e.res = 32'h0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0]; e.c = s[32];
        e.v = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      4'd1: begin
        e.res = a - b; e.c = (a >= b);
        e.v = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd7: begin e.res = a << sh; e.lat = sh + 1; end
      4'd8: begin e.res = a >> sh; e.lat = sh + 1; end
      4'd9: begin e.res = $signed(a) >>> sh; e.lat = sh + 1; end
`ifdef SEQ_ALU_MUL_EN
      4'd10: begin
        p = 64'(a) * 64'(b);
        e.res = p[31:0]; e.c = |p[63:32]; e.lat = 33;
      end
`endif
      default: e.res = 32'h0;
    endcase
    e.z = (e.res == 32'h0);
    e.n = e.res[31];
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge with inputs scrambled.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1; ALUControl = op; A = a; B = b;
    do begin
      #1;
      rdy = in_ready;
      @(posedge clk);
      n++;
      if (!rdy) @(negedge clk);
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++; errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end else begin
      sb.push_back(model(op, a, b));
    end
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
  endtask

  task automatic recv();
    exp_t e;
    int   lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("result", 64'(Result), 64'(e.res));
      chk("carry", 64'(Carry), 64'(e.c));
      chk("overflow", 64'(OverFlow), 64'(e.v));
      chk("zero", 64'(Zero), 64'(e.z));
      chk("negative", 64'(Negative), 64'(e.n));
    end
    got_res = Result;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 32'h0; B = 32'h0; ALUControl = 4'h0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_flags", 64'({Carry, OverFlow, Zero, Negative}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'(in_ready), 64'd1);

    send(4'd0, 32'h7FFF_FFFF, 32'h1);  recv();
    chk("add_ovf_result", 64'(got_res), 64'h8000_0000);
    send(4'd1, 32'h8000_0000, 32'h1);  recv();
    send(4'd1, 32'h2, 32'h5);          recv();
    chk("sub_neg_result", 64'(got_res), 64'hFFFF_FFFD);
    send(4'd0, 32'hFFFF_FFFF, 32'h1);  recv();
    send(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF); recv();
    send(4'd3, 32'hF000_0000, 32'h0000_000F); recv();
    send(4'd4, 32'hAAAA_5555, 32'hAAAA_5555); recv();
    send(4'd5, 32'hFFFF_FFFF, 32'h1);  recv();
    send(4'd6, 32'hFFFF_FFFF, 32'h1);  recv();
    send(4'd15, 32'h1234, 32'h5678);   recv();
    send(4'd9, 32'h8000_0000, 32'h4);  recv();
    chk("sra_result", 64'(got_res), 64'hF800_0000);
    send(4'd7, 32'hDEAD_BEEF, 32'h0);  recv();
    send(4'd7, 32'h0000_0003, 32'h1F); recv();
    send(4'd8, 32'h8000_0001, 32'h21); recv();
    send(4'd10, 32'h0001_0000, 32'h0001_0000); recv();
    chk("mul_result", 64'(got_res), 64'd0);

    // Backpressure hold, then back-to-back accept on the releasing edge
    send(4'd5, 32'h2, 32'h5);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(Result), 64'(e.res));
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; ALUControl = 4'd0; A = 32'h2; B = 32'h2;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(model(4'd0, 32'h2, 32'h2));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; A = $urandom; B = $urandom;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    recv();
    chk("b2b_result", 64'(got_res), 64'd4);

    for (int i = 0; i < 16; i++) begin
      send(4'($urandom_range(0, 15)), $urandom, $urandom);
      recv();
    end

    // Reset in the middle of a long shift
    send(4'd8, 32'hFFFF_0000, 32'd20);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(Result), 64'd0);
    chk("mid_rst_flags", 64'({Carry, OverFlow, Zero, Negative}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("post_rst_ready_high", 64'(in_ready), 64'd1);
    send(4'd0, 32'h5, 32'h2); recv();
    chk("post_rst_add", 64'(got_res), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
